// File: rtl/add32_seq.sv
// Sequential multi-precision adder: one shared 8-bit adder, one byte per cycle, LSB first.
// Optional subtract mode (op port) when ADD32_SEQ_SUB_EN is defined.

module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  assign {cout, s} = 9'(a) + 9'(b) + 9'(cin);
endmodule

module add32_seq #(
  parameter  int NB = 4,
  localparam int W  = 8 * NB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef ADD32_SEQ_SUB_EN
  input  logic         op,
`endif
  output logic [W-1:0] s,
  output logic         cout,
  output logic         busy,
  output logic         done
);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [NB-1:0][7:0] a_r, b_r, s_r;
  logic [IW-1:0]     idx;
  logic              carry;
  logic              cout_r, busy_r, done_r;
  logic [7:0]        sum;
  logic              sum_c;
  logic [W-1:0]      b_eff;
  logic              c_init;

  // Subtraction is a + ~b + 1: b is inverted once at acceptance, carry seeded with 1.
`ifdef ADD32_SEQ_SUB_EN
  assign b_eff  = op ? ~b : b;
  assign c_init = op ? 1'b1 : cin;
`else
  assign b_eff  = b;
  assign c_init = cin;
`endif

  adder8 u_adder (
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .cin  (carry),
    .s    (sum),
    .cout (sum_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b_eff;
            carry  <= c_init;
            idx    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          s_r[idx] <= sum;
          carry    <= sum_c;
          idx      <= idx + 1'b1;
          if (idx == IW'(NB - 1)) begin
            cout_r <= sum_c;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s    = s_r;
  assign cout = cout_r;
  assign busy = busy_r;
  assign done = done_r;
endmodule

// File: tb/tb_add32_seq.sv
// Scoreboard bench for add32_seq: stimulus pushes expected {cout,s}, a negedge monitor pops on done.

`ifndef SEED
`define SEED 1
`endif
`ifndef NP
`define NP 40
`endif

module tb_add32_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
`ifdef ADD32_SEQ_SUB_EN
  logic         op = 1'b0;
`endif
  logic [W-1:0] s;
  logic         cout, busy, done;

  add32_seq #(.NB(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADD32_SEQ_SUB_EN
    .op    (op),
`endif
    .s     (s),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] exp;
    int         acc;
    string      name;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse, checks result and latency.
  always @(negedge clk) begin
    if (busy && done) check("busy_done_overlap", 64'(1), 64'(0));
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        item_t it;
        it = q.pop_front();
        check({it.name, "_result"}, 64'({cout, s}), 64'(it.exp));
        check({it.name, "_latency"}, 64'(cyc), 64'(it.acc + NB));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy && !done) return;
    end
    check("idle_timeout", 64'(1), 64'(0));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) return;
    end
    check("done_timeout", 64'(q.size()), 64'(0));
    q.delete();
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic [W:0] exp, input string nm);
    wait_idle();
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    q.push_back('{exp, cyc, nm});
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seed;
    logic [W-1:0] ra, rb;
    logic         rc;
    seed = `SEED;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_s", 64'(s), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, {1'b0, 32'h0000_0100}, "ff_plus_1");
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b1, 32'h0000_0000}, "full_ripple");
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 32'h2345_6789}, "no_carry");
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 32'h0000_0000}, "msb_carry");
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, {1'b0, 32'h8000_0001}, "cin_ripple");
    do_op(32'h0000_0000, 32'h0000_0000, 1'b0, {1'b0, 32'h0000_0000}, "zero");

    // start held high; operands change during RUN and after the second acceptance
    wait_idle();
    a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    q.push_back('{{1'b0, 32'h0001_0000}, cyc, "held_first"});
    a = 32'hF0F0_F0F0; b = 32'h0F0F_0F0F; cin = 1'b1;
    repeat (NB + 2) @(posedge clk);
    #1;
    q.push_back('{{1'b1, 32'h0000_0000}, cyc, "held_second"});
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; cin = 1'b0;
    wait_drain();
    wait_drain();

    // reset during the second RUN cycle abandons the operation
    wait_idle();
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("abort_s", 64'(s), 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    repeat (NB + 3) @(negedge clk);
    do_op(32'h0000_0001, 32'h0000_0002, 1'b1, {1'b0, 32'h0000_0004}, "after_abort");

`ifdef ADD32_SEQ_SUB_EN
    op = 1'b1;
    do_op(32'h0000_0005, 32'h0000_0007, 1'b0, {1'b0, 32'hFFFF_FFFE}, "sub_borrow");
    do_op(32'h0000_0007, 32'h0000_0005, 1'b0, {1'b1, 32'h0000_0002}, "sub_no_borrow");
    op = 1'b0;
`endif

    for (int i = 0; i < `NP; i++) begin
      ra = $random(seed);
      rb = $random(seed);
      rc = ra[7] ^ rb[3];
      do_op(ra, rb, rc, 33'(ra) + 33'(rb) + 33'(rc), "random");
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
